// File: rtl/exh_stim_pkg.sv
// exh_stim_pkg
// Shared types and helpers for the exhaustive stimulus engine.
//   mode_t       : vector ordering selected at start (mode 3 behaves as MODE_BIN)
//   state_t      : sequencer FSM states
//   DEFAULT_POLY : default MISR feedback polynomial (CRC-16/CCITT)
//   seq_enc()    : maps a running index onto the vector actually driven
package exh_stim_pkg;

  localparam int MAX_WIDTH = 16;
  localparam logic [15:0] DEFAULT_POLY = 16'h1021;

  typedef enum logic [1:0] {
    MODE_BIN  = 2'd0,
    MODE_GRAY = 2'd1,
    MODE_DESC = 2'd2
  } mode_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // The index is zero-extended by the caller, so the Gray shift pulls in a
  // zero at the top and the inversion for descending order is made correct
  // by the caller truncating back to WIDTH bits.
  function automatic logic [MAX_WIDTH-1:0] seq_enc(input logic [MAX_WIDTH-1:0] idx,
                                                    input logic [1:0]           mode);
    case (mode)
      MODE_GRAY: seq_enc = idx ^ (idx >> 1);
      MODE_DESC: seq_enc = ~idx;
      default:   seq_enc = idx;
    endcase
  endfunction

endpackage

// File: rtl/misr.sv
// misr
// Multiple-input signature register: shift left, feed back POLY when the
// outgoing MSB is set, and XOR in the zero-extended input word.
//   clk, rst_n : clock, asynchronous active-low reset (signature -> 0)
//   clr        : synchronous clear to 0, has priority over en
//   en         : fold din into the signature on this edge
//   din        : response word (IN_WIDTH <= SIG_WIDTH)
//   sig        : current signature
module misr
  import exh_stim_pkg::*;
#(
  parameter int                   SIG_WIDTH = 16,
  parameter int                   IN_WIDTH  = 1,
  parameter logic [SIG_WIDTH-1:0] POLY      = DEFAULT_POLY
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 en,
  input  logic [IN_WIDTH-1:0]  din,
  output logic [SIG_WIDTH-1:0] sig
);

  logic [SIG_WIDTH-1:0] sig_next;

  always_comb begin
    sig_next = {sig[SIG_WIDTH-2:0], 1'b0} ^ (sig[SIG_WIDTH-1] ? POLY : '0) ^ SIG_WIDTH'(din);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig <= '0;
    end else if (clr) begin
      sig <= '0;
    end else if (en) begin
      sig <= sig_next;
    end
  end

endmodule

// File: rtl/exhaustive_stim_engine.sv
// exhaustive_stim_engine
// Walks all 2^WIDTH input vectors of a combinational DUT, holding each for
// HOLD cycles, and compresses the DUT response into a MISR signature.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : begin a run (only looked at in IDLE)
//   abort      : end a run early, wins over start
//   mode       : 0 ascending, 1 Gray, 2 descending, 3 ascending
//   stim       : vector to the DUT; stim_valid marks it live
//   resp       : DUT response, folded on the last cycle of each hold window
//   busy, done : run in progress / one-cycle completion pulse
//   vec_count  : vectors applied and sampled in the current/last run
//   signature  : MISR contents
//   dbg_state  : current FSM state (state_t encoding)
//
// Control semantics: start and abort are plain levels sampled on the rising
// edge. start is acted on only when the FSM is IDLE and abort is low; abort
// is acted on only in RUN. There is no ready/acknowledge: busy going high in
// the cycle after the sampling edge is the acceptance indication, and done
// is the completion indication. All outputs come straight from flops.
module exhaustive_stim_engine
  import exh_stim_pkg::*;
#(
  parameter int                   WIDTH     = 4,
  parameter int                   OUT_WIDTH = 1,
  parameter int                   HOLD      = 1,
  parameter int                   SIG_WIDTH = 16,
  parameter logic [SIG_WIDTH-1:0] POLY      = DEFAULT_POLY
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [1:0]           mode,
  output logic [WIDTH-1:0]     stim,
  output logic                 stim_valid,
  input  logic [OUT_WIDTH-1:0] resp,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH:0]       vec_count,
  output logic [SIG_WIDTH-1:0] signature,
  output logic [1:0]           dbg_state
);

  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);

  state_t           state_q, state_d;
  logic [1:0]       mode_q;
  logic [WIDTH-1:0] idx_q, idx_next;
  logic [HW-1:0]    hold_q;
  logic             launch, fold, last_vec;

  assign dbg_state = state_q;
  assign idx_next  = idx_q + WIDTH'(1);
  assign last_vec  = (idx_q == '1);

  // Next-state and per-edge strobes. fold is only raised when abort is low,
  // so an aborting edge never touches the MISR or the vector count.
  always_comb begin
    state_d = state_q;
    launch  = 1'b0;
    fold    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d = S_RUN;
          launch  = 1'b1;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (hold_q == HOLD_LAST) begin
          fold = 1'b1;
          if (last_vec) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q     <= 2'd0;
      idx_q      <= '0;
      hold_q     <= '0;
      vec_count  <= '0;
      stim       <= '0;
      stim_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      // Status flags are registered copies of where the FSM is going.
      stim_valid <= (state_d == S_RUN);
      busy       <= (state_d == S_RUN);
      done       <= (state_d == S_DONE);
      if (launch) begin
        mode_q    <= mode;
        idx_q     <= '0;
        hold_q    <= '0;
        vec_count <= '0;
        stim      <= WIDTH'(seq_enc(MAX_WIDTH'(0), mode));
      end else if (state_q == S_RUN && !abort) begin
        if (fold) begin
          hold_q    <= '0;
          vec_count <= vec_count + (WIDTH+1)'(1);
          if (!last_vec) begin
            idx_q <= idx_next;
            stim  <= WIDTH'(seq_enc(MAX_WIDTH'(idx_next), mode_q));
          end
        end else begin
          hold_q <= hold_q + HW'(1);
        end
      end
    end
  end

  misr #(
    .SIG_WIDTH (SIG_WIDTH),
    .IN_WIDTH  (OUT_WIDTH),
    .POLY      (POLY)
  ) u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (launch),
    .en    (fold),
    .din   (resp),
    .sig   (signature)
  );

endmodule
